// File: rtl/clp_out_writer.sv
// clp_out_writer
// Collects signed results from the CLP pipeline for one output feature map
// and streams them into the output buffer as registered write strobes.
// One run writes out_dim*out_dim samples to consecutive addresses from a
// programmable base, with optional ReLU clamping. The run also produces
// per-row and end-of-layer pulses. An illegal geometry at start skips the
// run and raises a sticky configuration error.

module clp_out_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  feature_size,
    input  logic [2:0]  current_kernel_size,
    input  logic [11:0] base_addr,
    input  logic        relu_en,
    input  logic        CLP_enable,
    input  logic        CLP_data_ready,
    input  logic [15:0] clp_result,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        row_done,
    output logic        layer_done,
    output logic        busy,
    output logic        cfg_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Control state
    logic [1:0]  state_q, state_d;
    logic        last_q, last_d;        // final sample taken, waiting for its write to leave
    logic        cfg_err_q, cfg_err_d;

    // Run configuration, captured on an accepted start
    logic [7:0]  out_dim_q, out_dim_d;
    logic        relu_q, relu_d;

    // Position counters
    logic [7:0]  col_q, col_d;
    logic [7:0]  row_q, row_d;
    logic [11:0] addr_cnt_q, addr_cnt_d;

    // Registered write port and status pulses
    logic        wr_en_q, wr_en_d;
    logic [11:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        row_done_q, row_done_d;
    logic        layer_done_q, layer_done_d;
    logic        busy_q, busy_d;

    // Combinational helpers
    logic [7:0]  k_eff;
    logic        cfg_illegal;
    logic        start_ok;
    logic        accept;
    logic [7:0]  dim_m1;
    logic        col_last;
    logic        row_last;

    // Map the kernel code onto its effective size; unknown codes act as 1x1.
    always_comb begin
        k_eff = 8'd1;
        case (current_kernel_size)
            3'd3:    k_eff = 8'd3;
            3'd5:    k_eff = 8'd5;
            default: k_eff = 8'd1;
        endcase
    end

    // Start qualification, sample acceptance and end-of-row/end-of-map detection.
    always_comb begin
        cfg_illegal = (feature_size == 8'd0) || (feature_size < k_eff);
        start_ok    = (state_q == ST_IDLE) && start;
        // Once the final sample is taken, further qualifier cycles are ignored.
        accept      = (state_q == ST_RUN) && !last_q && CLP_enable && CLP_data_ready;
        dim_m1      = out_dim_q - 8'd1;
        col_last    = (col_q == dim_m1);
        row_last    = (row_q == dim_m1);
    end

    // FSM next state. RUN ends only after the final write has been presented,
    // so DONE (and layer_done) follows the last wr_en strobe by one cycle.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state_q;
        last_d    = last_q;
        cfg_err_d = cfg_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    if (cfg_illegal) begin
                        state_d   = ST_DONE;
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d   = ST_RUN;
                        cfg_err_d = 1'b0;
                    end
                    last_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept && col_last && row_last) begin
                    last_d = 1'b1;
                end else if (last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                last_d  = 1'b0;
            end
        endcase
    end

    // Configuration capture and column/row/address counters.
    always_comb begin
        out_dim_d  = out_dim_q;
        relu_d     = relu_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_cnt_d = addr_cnt_q;
        if (start_ok && !cfg_illegal) begin
            out_dim_d  = feature_size - k_eff + 8'd1;
            relu_d     = relu_en;
            col_d      = 8'd0;
            row_d      = 8'd0;
            addr_cnt_d = base_addr;
        end else if (accept) begin
            // 12-bit address counter wraps naturally modulo 4096.
            addr_cnt_d = addr_cnt_q + 12'd1;
            if (col_last) begin
                col_d = 8'd0;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    // Write staging: an accepted sample appears on the write port one cycle later.
    always_comb begin
        wr_en_d    = 1'b0;
        row_done_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (accept) begin
            wr_en_d    = 1'b1;
            row_done_d = col_last;
            wr_addr_d  = addr_cnt_q;
            wr_data_d  = (relu_q && clp_result[15]) ? 16'h0000 : clp_result;
        end
    end

    // Status outputs are registered from the next-state so they line up with the state.
    always_comb begin
        layer_done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
        busy_d       = (state_d != ST_IDLE);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            layer_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            last_q       <= last_d;
            cfg_err_q    <= cfg_err_d;
            layer_done_q <= layer_done_d;
            busy_q       <= busy_d;
        end
    end

    // Datapath registers: configuration, counters and the write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_dim_q  <= 8'd0;
            relu_q     <= 1'b0;
            col_q      <= 8'd0;
            row_q      <= 8'd0;
            addr_cnt_q <= 12'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 12'd0;
            wr_data_q  <= 16'd0;
            row_done_q <= 1'b0;
        end else begin
            out_dim_q  <= out_dim_d;
            relu_q     <= relu_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_cnt_q <= addr_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            row_done_q <= row_done_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign row_done   = row_done_q;
    assign layer_done = layer_done_q;
    assign busy       = busy_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_clp_out_writer.sv
// Self-checking bench for clp_out_writer. A behavioural model predicts, from
// the geometry and from the qualifier pattern the bench drives, which write
// must appear on each cycle: its address, its data, and the row/layer pulses.

module tb_clp_out_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  feature_size;
    logic [2:0]  current_kernel_size;
    logic [11:0] base_addr;
    logic        relu_en;
    logic        CLP_enable;
    logic        CLP_data_ready;
    logic [15:0] clp_result;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        row_done;
    logic        layer_done;
    logic        busy;
    logic        cfg_err;

    int          n_vec = 0;
    int          n_err = 0;
    logic        model_cfg = 1'b0;     // expected sticky cfg_err
    logic [11:0] last_wr_addr;
    logic [15:0] last_wr_data;
    int          last_write_cnt;

    clp_out_writer dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .feature_size        (feature_size),
        .current_kernel_size (current_kernel_size),
        .base_addr           (base_addr),
        .relu_en             (relu_en),
        .CLP_enable          (CLP_enable),
        .CLP_data_ready      (CLP_data_ready),
        .clp_result          (clp_result),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .row_done            (row_done),
        .layer_done          (layer_done),
        .busy                (busy),
        .cfg_err             (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete feature-map run, checked cycle by cycle against the model.
    // abort_after > 0 returns right after that many writes have been seen.
    task automatic run_map(input logic [7:0] fs, input logic [2:0] ks, input logic [11:0] base,
                           input logic relu, input int gap_pct, input logic use_fixed,
                           input logic [15:0] fixed_data, input int abort_after, input string tag);
        int          k;
        int          n;
        int          total;
        int          i;
        int          budget;
        int          rd_seen;
        logic        e;
        logic        r;
        logic        acc;
        logic [15:0] din;
        logic [4:0]  got;
        logic [4:0]  exp_ctrl;
        logic [11:0] exp_addr;
        logic [15:0] exp_data;
        k = (ks == 3'd3) ? 3 : ((ks == 3'd5) ? 5 : 1);
        last_write_cnt = 0;

        @(negedge clk);
        start               = 1'b1;
        feature_size        = fs;
        current_kernel_size = ks;
        base_addr           = base;
        relu_en             = relu;
        CLP_enable          = 1'($urandom_range(1));
        CLP_data_ready      = 1'($urandom_range(1));
        clp_result          = 16'($urandom);
        @(negedge clk);
        // Configuration inputs change freely after start; only the start cycle counts.
        start               = 1'b0;
        feature_size        = 8'($urandom);
        current_kernel_size = 3'($urandom);
        base_addr           = 12'($urandom);
        relu_en             = 1'($urandom_range(1));

        got = {wr_en, row_done, layer_done, busy, cfg_err};
        if (fs == 8'd0 || int'(fs) < k) begin
            model_cfg = 1'b1;
            n_vec++;
            if (got !== 5'b00111) begin
                n_err++;
                $display("FAIL %s cfg_err start: {wr,row,layer,busy,cfg} got %b exp %b", tag, got, 5'b00111);
            end
            @(negedge clk);
            got = {wr_en, row_done, layer_done, busy, cfg_err};
            n_vec++;
            if (got !== 5'b00001) begin
                n_err++;
                $display("FAIL %s cfg_err after: {wr,row,layer,busy,cfg} got %b exp %b", tag, got, 5'b00001);
            end
            return;
        end

        model_cfg = 1'b0;
        n       = int'(fs) - k + 1;
        total   = n * n;
        budget  = total * 8 + 50;
        rd_seen = 0;
        i       = 0;
        n_vec++;
        if (got !== 5'b00010) begin
            n_err++;
            $display("FAIL %s run entry: {wr,row,layer,busy,cfg} got %b exp %b", tag, got, 5'b00010);
        end

        while (i < total && budget > 0) begin
            budget--;
            e   = ($urandom_range(99) >= gap_pct);
            r   = ($urandom_range(99) >= gap_pct);
            din = use_fixed ? fixed_data : 16'($urandom);
            CLP_enable     = e;
            CLP_data_ready = r;
            clp_result     = din;
            // Stray starts with different settings while busy must be ignored.
            start = (gap_pct > 0) && ($urandom_range(7) == 0);
            if (start) begin
                feature_size = 8'($urandom);
                base_addr    = 12'($urandom);
                relu_en      = 1'($urandom_range(1));
            end
            acc = e && r;
            @(negedge clk);
            start    = 1'b0;
            exp_ctrl = {acc, acc && ((i % n) == n - 1), 1'b0, 1'b1, 1'b0};
            got      = {wr_en, row_done, layer_done, busy, cfg_err};
            n_vec++;
            if (got !== exp_ctrl) begin
                n_err++;
                $display("FAIL %s ctrl at write %0d: {wr,row,layer,busy,cfg} got %b exp %b", tag, i, got, exp_ctrl);
            end
            if (row_done === 1'b1) rd_seen++;
            if (acc) begin
                exp_addr = base + 12'(i);
                exp_data = (relu && din[15]) ? 16'h0000 : din;
                n_vec++;
                if (wr_addr !== exp_addr) begin
                    n_err++;
                    $display("FAIL %s wr_addr at write %0d: got %h exp %h", tag, i, wr_addr, exp_addr);
                end
                n_vec++;
                if (wr_data !== exp_data) begin
                    n_err++;
                    $display("FAIL %s wr_data at write %0d: got %h exp %h", tag, i, wr_data, exp_data);
                end
                last_wr_addr = wr_addr;
                last_wr_data = wr_data;
                i++;
                last_write_cnt = i;
            end
            if (abort_after > 0 && i == abort_after) return;
        end

        if (i < total) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: %0d writes modelled, %0d required", tag, i, total);
            CLP_enable     = 1'b0;
            CLP_data_ready = 1'b0;
            return;
        end

        // Cycle after the last write: DONE with layer_done, qualifiers still ignored.
        CLP_enable     = 1'($urandom_range(1));
        CLP_data_ready = 1'($urandom_range(1));
        @(negedge clk);
        got = {wr_en, row_done, layer_done, busy, cfg_err};
        n_vec++;
        if (got !== 5'b00110) begin
            n_err++;
            $display("FAIL %s done cycle: {wr,row,layer,busy,cfg} got %b exp %b", tag, got, 5'b00110);
        end
        // Back in IDLE.
        CLP_enable     = 1'($urandom_range(1));
        CLP_data_ready = 1'($urandom_range(1));
        @(negedge clk);
        got = {wr_en, row_done, layer_done, busy, cfg_err};
        n_vec++;
        if (got !== 5'b00000) begin
            n_err++;
            $display("FAIL %s idle after run: {wr,row,layer,busy,cfg} got %b exp %b", tag, got, 5'b00000);
        end
        n_vec++;
        if (rd_seen !== n) begin
            n_err++;
            $display("FAIL %s row_done count: got %0d exp %0d", tag, rd_seen, n);
        end
        CLP_enable     = 1'b0;
        CLP_data_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [32:0] got;
        rst = 1'b0;
        #3;
        got = {wr_en, row_done, layer_done, busy, cfg_err, wr_addr, wr_data};
        n_vec++;
        if (got !== 33'd0) begin
            n_err++;
            $display("FAIL reset outputs: got %h exp 0", got);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got = {wr_en, row_done, layer_done, busy, cfg_err, wr_addr, wr_data};
        n_vec++;
        if (got !== 33'd0) begin
            n_err++;
            $display("FAIL post-reset idle outputs: got %h exp 0", got);
        end
    endtask

    task automatic test_idle_ignore();
        logic [4:0] got;
        for (int c = 0; c < 4; c++) begin
            CLP_enable     = 1'b1;
            CLP_data_ready = 1'b1;
            clp_result     = 16'($urandom);
            @(negedge clk);
            got = {wr_en, row_done, layer_done, busy, cfg_err};
            n_vec++;
            if (got !== {4'b0000, model_cfg}) begin
                n_err++;
                $display("FAIL idle qualifiers cycle %0d: got %b exp %b", c, got, {4'b0000, model_cfg});
            end
        end
        CLP_enable     = 1'b0;
        CLP_data_ready = 1'b0;
    endtask

    task automatic test_full_map();
        run_map(8'd28, 3'd5, 12'h100, 1'b0, 0, 1'b0, 16'h0, 0, "full28k5");
        n_vec++;
        if (last_write_cnt !== 576) begin
            n_err++;
            $display("FAIL full28k5 write count: got %0d exp 576", last_write_cnt);
        end
        n_vec++;
        if (last_wr_addr !== 12'h33F) begin
            n_err++;
            $display("FAIL full28k5 last addr: got %h exp 33f", last_wr_addr);
        end
    endtask

    task automatic test_gaps();
        run_map(8'd8, 3'd3, 12'($urandom), 1'b1, 45, 1'b0, 16'h0, 0, "gaps8k3");
        n_vec++;
        if (last_write_cnt !== 36) begin
            n_err++;
            $display("FAIL gaps8k3 write count: got %0d exp 36", last_write_cnt);
        end
    endtask

    task automatic test_relu();
        run_map(8'd1, 3'd1, 12'h010, 1'b1, 0, 1'b1, 16'hFF80, 0, "relu_neg");
        n_vec++;
        if (last_wr_data !== 16'h0000) begin
            n_err++;
            $display("FAIL relu_neg data: got %h exp 0000", last_wr_data);
        end
        run_map(8'd1, 3'd1, 12'h011, 1'b1, 0, 1'b1, 16'h007F, 0, "relu_pos");
        n_vec++;
        if (last_wr_data !== 16'h007F) begin
            n_err++;
            $display("FAIL relu_pos data: got %h exp 007f", last_wr_data);
        end
        run_map(8'd1, 3'd1, 12'h012, 1'b0, 0, 1'b1, 16'hFF80, 0, "relu_off");
        n_vec++;
        if (last_wr_data !== 16'hFF80) begin
            n_err++;
            $display("FAIL relu_off data: got %h exp ff80", last_wr_data);
        end
    endtask

    task automatic test_wrap();
        run_map(8'd2, 3'd1, 12'hFFE, 1'b0, 20, 1'b0, 16'h0, 0, "addr_wrap");
        n_vec++;
        if (last_wr_addr !== 12'h001) begin
            n_err++;
            $display("FAIL addr_wrap last addr: got %h exp 001", last_wr_addr);
        end
    endtask

    task automatic test_cfg_err();
        run_map(8'd2, 3'd5, 12'h200, 1'b0, 0, 1'b0, 16'h0, 0, "cfg_2k5");
        test_idle_ignore();
        run_map(8'd0, 3'd1, 12'h200, 1'b0, 0, 1'b0, 16'h0, 0, "cfg_0k1");
        // A legal start clears the sticky flag.
        run_map(8'd3, 3'd3, 12'h300, 1'b0, 0, 1'b0, 16'h0, 0, "cfg_clear");
    endtask

    task automatic test_mid_reset();
        logic [32:0] got;
        logic [11:0] base;
        base = 12'($urandom);
        run_map(8'd8, 3'd1, base, 1'b0, 0, 1'b0, 16'h0, 10, "midrst_a");
        CLP_enable     = 1'b1;
        CLP_data_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        got = {wr_en, row_done, layer_done, busy, cfg_err, wr_addr, wr_data};
        n_vec++;
        if (got !== 33'd0) begin
            n_err++;
            $display("FAIL midrst async clear: got %h exp 0", got);
        end
        @(negedge clk);
        got = {wr_en, row_done, layer_done, busy, cfg_err, wr_addr, wr_data};
        n_vec++;
        if (got !== 33'd0) begin
            n_err++;
            $display("FAIL midrst held: got %h exp 0", got);
        end
        rst       = 1'b1;
        model_cfg = 1'b0;
        @(negedge clk);
        got = {wr_en, row_done, layer_done, busy, cfg_err, wr_addr, wr_data};
        n_vec++;
        if (got !== 33'd0) begin
            n_err++;
            $display("FAIL midrst after release: got %h exp 0", got);
        end
        CLP_enable     = 1'b0;
        CLP_data_ready = 1'b0;
        run_map(8'd8, 3'd1, base, 1'b0, 0, 1'b0, 16'h0, 0, "midrst_b");
    endtask

    task automatic test_random_runs();
        for (int t = 0; t < 8; t++) begin
            run_map(8'($urandom_range(14)), 3'($urandom), 12'($urandom), 1'($urandom_range(1)),
                    30, 1'b0, 16'h0, 0, "random");
        end
    endtask

    initial begin
        rst                 = 1'b0;
        start               = 1'b0;
        feature_size        = 8'd0;
        current_kernel_size = 3'd0;
        base_addr           = 12'd0;
        relu_en             = 1'b0;
        CLP_enable          = 1'b0;
        CLP_data_ready      = 1'b0;
        clp_result          = 16'd0;
        last_wr_addr        = 12'd0;
        last_wr_data        = 16'd0;
        last_write_cnt      = 0;

        test_reset();
        test_idle_ignore();
        test_full_map();
        test_gaps();
        test_relu();
        test_wrap();
        test_cfg_err();
        test_mid_reset();
        test_random_runs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
